// File: rtl/contador_hex.sv
// Control stage for the 4-digit hex display: debounced start/dir/clear buttons,
// switch load, and a prescaled up/down counter that feeds the nibble mux.

module contador_hex_btn #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic press
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [1:0]    sync;
    logic          deb, deb_q;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync  <= '0;
            deb   <= 1'b0;
            deb_q <= 1'b0;
            cnt   <= '0;
        end else begin
            sync  <= {sync[0], raw};
            deb_q <= deb;
            // Any cycle that agrees with the accepted level restarts the run.
            if (sync[1] == deb)
                cnt <= '0;
            else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                deb <= sync[1];
                cnt <= '0;
            end else
                cnt <= cnt + CW'(1);
        end
    end

    assign press = deb & ~deb_q;
endmodule

module contador_hex_ctrl #(
    parameter int CLK_FREQ_HZ     = 100_000_000,
    parameter int TICK_HZ         = 4,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic        CLK100MHZ,
    input  logic        reset,
    input  logic        btn_start,
    input  logic        btn_dir,
    input  logic        btn_clear,
    input  logic        load_en,
    input  logic [15:0] load_val,
    output logic [15:0] count,
    output logic        running,
    output logic        dir_down,
    output logic        tick
);
    localparam int TICK_DIV = CLK_FREQ_HZ / TICK_HZ;
    localparam int PW       = $clog2(TICK_DIV);
    localparam int NUM_BTN  = 3;

    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

    logic [NUM_BTN-1:0] btn_raw, press;
    logic               start_p, dir_p, clear_p;

    state_t        state, state_nxt;
    logic [15:0]   count_nxt;
    logic [PW-1:0] presc, presc_nxt;
    logic          dir_nxt, tick_nxt;

    assign btn_raw = {btn_clear, btn_dir, btn_start};

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        contador_hex_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
            .clk   (CLK100MHZ),
            .reset (reset),
            .raw   (btn_raw[i]),
            .press (press[i])
        );
    end

    assign start_p = press[0];
    assign dir_p   = press[1];
    assign clear_p = press[2];

    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            state    <= IDLE;
            count    <= '0;
            presc    <= '0;
            dir_down <= 1'b0;
            tick     <= 1'b0;
        end else begin
            state    <= state_nxt;
            count    <= count_nxt;
            presc    <= presc_nxt;
            dir_down <= dir_nxt;
            tick     <= tick_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        presc_nxt = presc;
        tick_nxt  = 1'b0;
        dir_nxt   = dir_down ^ dir_p;

        if (clear_p) begin
            state_nxt = IDLE;
            count_nxt = '0;
            presc_nxt = '0;
        end else begin
            case (state)
                IDLE:    if (start_p) state_nxt = RUN;
                RUN:     if (start_p) state_nxt = PAUSE;
                PAUSE:   if (start_p) state_nxt = RUN;
                default: state_nxt = IDLE;
            endcase

            if (load_en) begin
                count_nxt = load_val;
                presc_nxt = '0;
            end else if (state == RUN) begin
                // Step uses the direction in force before this edge.
                if (presc == PW'(TICK_DIV - 1)) begin
                    count_nxt = dir_down ? count - 16'd1 : count + 16'd1;
                    presc_nxt = '0;
                    tick_nxt  = 1'b1;
                end else
                    presc_nxt = presc + PW'(1);
            end

            // Leaving RUN parks the prescaler so re-entry always starts from 0.
            if (state_nxt != RUN) presc_nxt = '0;
        end
    end

    assign running = (state == RUN);
endmodule

// File: tb/tb_contador_hex_ctrl.sv
// Directed bench for contador_hex_ctrl at TICK_DIV=10, DEBOUNCE_CYCLES=3.

module tb_contador_hex_ctrl;
    logic        CLK100MHZ = 1'b0;
    logic        reset = 1'b1;
    logic        btn_start = 1'b0, btn_dir = 1'b0, btn_clear = 1'b0;
    logic        load_en = 1'b0;
    logic [15:0] load_val = '0;
    logic [15:0] count;
    logic        running, dir_down, tick;

    int n_cmp = 0;
    int n_err = 0;

    contador_hex_ctrl #(.CLK_FREQ_HZ(40), .TICK_HZ(4), .DEBOUNCE_CYCLES(3)) dut (
        .CLK100MHZ (CLK100MHZ),
        .reset     (reset),
        .btn_start (btn_start),
        .btn_dir   (btn_dir),
        .btn_clear (btn_clear),
        .load_en   (load_en),
        .load_val  (load_val),
        .count     (count),
        .running   (running),
        .dir_down  (dir_down),
        .tick      (tick)
    );

    always #5 CLK100MHZ = ~CLK100MHZ;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK100MHZ);
            #1;
        end
    endtask

    task automatic do_reset;
        btn_start = 0; btn_dir = 0; btn_clear = 0; load_en = 0;
        reset = 1;
        step(1);
        reset = 0;
    endtask

    // Raw high for 6 edges: the press takes effect on the 6th.
    task automatic press_btn(input int which);
        if (which == 0) btn_start = 1;
        else if (which == 1) btn_dir = 1;
        else btn_clear = 1;
        step(6);
        btn_start = 0; btn_dir = 0; btn_clear = 0;
    endtask

    task automatic do_load(input logic [15:0] v);
        load_val = v;
        load_en  = 1;
        step(1);
        load_en  = 0;
    endtask

    task automatic test_reset;
        reset = 1;
        step(2);
        n_cmp++; if (count !== 16'h0000) begin n_err++; $display("FAIL rst_count: got %h want 0000", count); end
        n_cmp++; if ({running, dir_down, tick} !== 3'b000) begin n_err++; $display("FAIL rst_flags: got %b want 000", {running, dir_down, tick}); end
        reset = 0;
    endtask

    task automatic test_start_count;
        do_reset();
        btn_start = 1;
        for (int e = 1; e <= 30; e++) begin
            step(1);
            if (e == 20) btn_start = 0;
            case (e)
                5:  begin n_cmp++; if (running !== 1'b0) begin n_err++; $display("FAIL t1_run_e5: got %b want 0", running); end end
                6:  begin n_cmp++; if (running !== 1'b1) begin n_err++; $display("FAIL t1_run_e6: got %b want 1", running); end end
                15: begin n_cmp++; if ({count, tick} !== {16'h0000, 1'b0}) begin n_err++; $display("FAIL t1_e15: got %h/%b want 0000/0", count, tick); end end
                16: begin n_cmp++; if ({count, tick} !== {16'h0001, 1'b1}) begin n_err++; $display("FAIL t1_e16: got %h/%b want 0001/1", count, tick); end end
                17: begin n_cmp++; if ({count, tick} !== {16'h0001, 1'b0}) begin n_err++; $display("FAIL t1_e17: got %h/%b want 0001/0", count, tick); end end
                26: begin n_cmp++; if ({count, tick} !== {16'h0002, 1'b1}) begin n_err++; $display("FAIL t1_e26: got %h/%b want 0002/1", count, tick); end end
                27: begin n_cmp++; if (tick !== 1'b0) begin n_err++; $display("FAIL t1_e27_tick: got %b want 0", tick); end end
                default: ;
            endcase
        end
    endtask

    task automatic test_glitch;
        do_reset();
        btn_start = 1; step(2); btn_start = 0;
        step(10);
        n_cmp++; if (running !== 1'b0) begin n_err++; $display("FAIL t2_glitch: got %b want 0", running); end
        btn_start = 1; step(3); btn_start = 0;
        step(2);
        n_cmp++; if (running !== 1'b0) begin n_err++; $display("FAIL t2_e5: got %b want 0", running); end
        step(1);
        n_cmp++; if (running !== 1'b1) begin n_err++; $display("FAIL t2_e6: got %b want 1", running); end
    endtask

    task automatic test_load_wrap;
        do_reset();
        do_load(16'hFFFE);
        n_cmp++; if ({count, running} !== {16'hFFFE, 1'b0}) begin n_err++; $display("FAIL t3_load: got %h/%b want fffe/0", count, running); end
        press_btn(0);
        n_cmp++; if (running !== 1'b1) begin n_err++; $display("FAIL t3_run: got %b want 1", running); end
        step(9);
        n_cmp++; if ({count, tick} !== {16'hFFFE, 1'b0}) begin n_err++; $display("FAIL t3_pre: got %h/%b want fffe/0", count, tick); end
        step(1);
        n_cmp++; if ({count, tick} !== {16'hFFFF, 1'b1}) begin n_err++; $display("FAIL t3_up1: got %h/%b want ffff/1", count, tick); end
        step(10);
        n_cmp++; if ({count, tick} !== {16'h0000, 1'b1}) begin n_err++; $display("FAIL t3_wrap_up: got %h/%b want 0000/1", count, tick); end
        press_btn(1);
        n_cmp++; if ({dir_down, count} !== {1'b1, 16'h0000}) begin n_err++; $display("FAIL t3_dir: got %b/%h want 1/0000", dir_down, count); end
        step(3);
        n_cmp++; if (count !== 16'h0000) begin n_err++; $display("FAIL t3_dir_hold: got %h want 0000", count); end
        step(1);
        n_cmp++; if ({count, tick} !== {16'hFFFF, 1'b1}) begin n_err++; $display("FAIL t3_wrap_dn: got %h/%b want ffff/1", count, tick); end
        step(10);
        n_cmp++; if (count !== 16'hFFFE) begin n_err++; $display("FAIL t3_dn2: got %h want fffe", count); end
    endtask

    task automatic test_pause;
        logic saw_tick;
        do_reset();
        do_load(16'h00A4);
        press_btn(0);
        step(10);
        n_cmp++; if ({count, tick} !== {16'h00A5, 1'b1}) begin n_err++; $display("FAIL t4_a5: got %h/%b want 00a5/1", count, tick); end
        press_btn(0);
        n_cmp++; if ({count, running} !== {16'h00A5, 1'b0}) begin n_err++; $display("FAIL t4_pause: got %h/%b want 00a5/0", count, running); end
        saw_tick = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step(1);
            if (tick) saw_tick = 1'b1;
        end
        n_cmp++; if ({count, saw_tick} !== {16'h00A5, 1'b0}) begin n_err++; $display("FAIL t4_hold: got %h/%b want 00a5/0", count, saw_tick); end
        press_btn(0);
        n_cmp++; if (running !== 1'b1) begin n_err++; $display("FAIL t4_resume: got %b want 1", running); end
        step(9);
        n_cmp++; if (count !== 16'h00A5) begin n_err++; $display("FAIL t4_pre: got %h want 00a5", count); end
        step(1);
        n_cmp++; if ({count, tick} !== {16'h00A6, 1'b1}) begin n_err++; $display("FAIL t4_a6: got %h/%b want 00a6/1", count, tick); end
    endtask

    task automatic test_clear_priority;
        do_reset();
        press_btn(1);
        step(6);
        press_btn(0);
        step(6);
        do_load(16'h1234);
        n_cmp++; if ({count, running} !== {16'h1234, 1'b1}) begin n_err++; $display("FAIL t5_setup: got %h/%b want 1234/1", count, running); end
        btn_start = 1; btn_clear = 1;
        step(6);
        btn_start = 0; btn_clear = 0;
        n_cmp++; if ({count, running, dir_down} !== {16'h0000, 1'b0, 1'b1}) begin n_err++; $display("FAIL t5_clear: got %h/%b/%b want 0000/0/1", count, running, dir_down); end
        step(10);
        n_cmp++; if ({count, running} !== {16'h0000, 1'b0}) begin n_err++; $display("FAIL t5_after: got %h/%b want 0000/0", count, running); end
        press_btn(0);
        step(6);
        load_val = 16'h5555;
        btn_clear = 1;
        step(5);
        load_en = 1;
        step(1);
        load_en = 0; btn_clear = 0;
        n_cmp++; if ({count, running} !== {16'h0000, 1'b0}) begin n_err++; $display("FAIL t5_clr_load: got %h/%b want 0000/0", count, running); end
    endtask

    task automatic test_reset_mid_run;
        do_reset();
        press_btn(1);
        step(6);
        do_load(16'h0042);
        btn_start = 1;
        step(6);
        n_cmp++; if (running !== 1'b1) begin n_err++; $display("FAIL t6_run: got %b want 1", running); end
        step(7);
        n_cmp++; if (count !== 16'h0042) begin n_err++; $display("FAIL t6_pre: got %h want 0042", count); end
        reset = 1;
        step(1);
        n_cmp++; if ({count, running, dir_down, tick} !== {16'h0000, 3'b000}) begin n_err++; $display("FAIL t6_rst: got %h/%b/%b/%b want 0000/0/0/0", count, running, dir_down, tick); end
        reset = 0;
        step(5);
        n_cmp++; if (running !== 1'b0) begin n_err++; $display("FAIL t6_e5: got %b want 0", running); end
        step(1);
        n_cmp++; if (running !== 1'b1) begin n_err++; $display("FAIL t6_e6: got %b want 1", running); end
        btn_start = 0;
        step(20);
        n_cmp++; if (running !== 1'b1) begin n_err++; $display("FAIL t6_single: got %b want 1", running); end
    endtask

    initial begin
        test_reset();
        test_start_count();
        test_glitch();
        test_load_wrap();
        test_pause();
        test_clear_priority();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
